// File: rtl/cpu_int_pkg.sv
// rtl/cpu_int_pkg.sv - shared types, defaults and helpers for the interrupt conditioner
package cpu_int_pkg;

  typedef enum logic {
    INT_LEVEL = 1'b0,
    INT_EDGE  = 1'b1
  } int_mode_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DBW         = 4;

  // Index width for n items, never narrower than one bit
  function automatic int chw(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_chan_filter.sv
// rtl/int_chan_filter.sv - per-channel synchroniser, polarity select and debounce filter
module int_chan_filter
  import cpu_int_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DBW         = DEF_DBW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pin,
  input  logic           pol,
  input  logic [DBW-1:0] debounce_cyc,
  output logic           filt_next,
  output logic           filt_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw;
  logic                   filt_q;
  logic [DBW-1:0]         cnt_q;
  logic [DBW-1:0]         cnt_d;

  // Metastability chain; the pin is asynchronous to clk
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  // Active-low pins are inverted here so everything downstream is active-high
  assign raw = sync_q[SYNC_STAGES-1] ^ pol;

  // Debounce: filt only follows raw once it has differed for debounce_cyc+1 edges.
  // The counter is not clamped when debounce_cyc shrinks mid-count; it wraps.
  always_comb begin
    filt_next = filt_q;
    cnt_d     = cnt_q;
    if (raw == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == debounce_cyc) begin
      filt_next = raw;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_next;
      cnt_q  <= cnt_d;
    end
  end

  // Rise is reported on the edge where filt itself goes high, so pending can latch in step
  assign filt_rise = filt_next & ~filt_q;

endmodule

// File: rtl/cpu_int_conditioner.sv
// rtl/cpu_int_conditioner.sv - multi-channel interrupt front-end driving the 6502 irq/nmi inputs
module cpu_int_conditioner
  import cpu_int_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DBW         = DEF_DBW,
  parameter int NMI_CH      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       int_in,
  input  logic [NUM_CH-1:0]       cfg_pol,
  input  logic [NUM_CH-1:0]       cfg_edge,
  input  logic [NUM_CH-1:0]       cfg_mask,
  input  logic [DBW-1:0]          debounce_cyc,
  input  logic                    ack_valid,
  input  logic [chw(NUM_CH)-1:0]  ack_ch,
  output logic [NUM_CH-1:0]       pending,
  output logic                    irq,
  output logic                    nmi,
  output logic                    irq_valid,
  output logic [chw(NUM_CH)-1:0]  irq_id
);

  localparam int IDW = chw(NUM_CH);
  localparam logic [NUM_CH-1:0] NMI_SEL = {{(NUM_CH-1){1'b0}}, 1'b1} << NMI_CH;

  logic [NUM_CH-1:0] filt_next;
  logic [NUM_CH-1:0] filt_rise;
  logic [NUM_CH-1:0] ack_hit;
  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] masked;
  logic [NUM_CH-1:0] irq_src;
  logic [IDW-1:0]    id_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    int_chan_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DBW         (DBW)
    ) u_filt (
      .clk          (clk),
      .rst          (rst),
      .pin          (int_in[g]),
      .pol          (cfg_pol[g]),
      .debounce_cyc (debounce_cyc),
      .filt_next    (filt_next[g]),
      .filt_rise    (filt_rise[g])
    );
  end

  // Decode the acknowledge; out-of-range channel numbers match nothing
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ack_hit[i] = ack_valid && (ack_ch == IDW'(i));
    end
  end

  // Next pending: level channels mirror filt, edge channels latch rises (set beats ack)
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int_mode_e'(cfg_edge[i]) == INT_EDGE) begin
        pending_d[i] = filt_rise[i] | (pending[i] & ~ack_hit[i]);
      end else begin
        pending_d[i] = filt_next[i];
      end
    end
  end

  // Pending latch, kept even for masked channels
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_d;
    end
  end

  assign masked  = pending & cfg_mask;
  assign irq_src = masked & ~NMI_SEL;

  // Lowest-index masked irq channel wins
  always_comb begin
    id_d = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (irq_src[i]) begin
        id_d = IDW'(i);
      end
    end
  end

  // Core-facing outputs, registered one cycle behind pending
  always_ff @(posedge clk) begin
    if (rst) begin
      irq       <= 1'b0;
      nmi       <= 1'b0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      irq       <= |irq_src;
      nmi       <= |(masked & NMI_SEL);
      irq_valid <= |irq_src;
      irq_id    <= id_d;
    end
  end

endmodule

// File: tb/tb_cpu_int_conditioner.sv
// tb/tb_cpu_int_conditioner.sv - directed self-checking bench for cpu_int_conditioner
module tb_cpu_int_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] int_in = '0;
  logic [3:0] cfg_pol = '0;
  logic [3:0] cfg_edge = 4'hF;
  logic [3:0] cfg_mask = 4'hF;
  logic [3:0] debounce_cyc = '0;
  logic       ack_valid = 1'b0;
  logic [1:0] ack_ch = '0;
  logic [3:0] pending;
  logic       irq;
  logic       nmi;
  logic       irq_valid;
  logic [1:0] irq_id;

  int n_cmp = 0;
  int n_err = 0;

  cpu_int_conditioner #(
    .NUM_CH      (4),
    .SYNC_STAGES (2),
    .DBW         (4),
    .NMI_CH      (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .int_in       (int_in),
    .cfg_pol      (cfg_pol),
    .cfg_edge     (cfg_edge),
    .cfg_mask     (cfg_mask),
    .debounce_cyc (debounce_cyc),
    .ack_valid    (ack_valid),
    .ack_ch       (ack_ch),
    .pending      (pending),
    .irq          (irq),
    .nmi          (nmi),
    .irq_valid    (irq_valid),
    .irq_id       (irq_id)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack(input logic [1:0] ch);
    ack_valid = 1'b1;
    ack_ch    = ch;
    tick(1);
    ack_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rst_pending: got %b want %b", pending, 4'b0000); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL rst_nmi: got %b want 0", nmi); end
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL rst_irq_valid: got %b want 0", irq_valid); end
    n_cmp++; if (irq_id !== 2'd0) begin n_err++; $display("FAIL rst_irq_id: got %0d want 0", irq_id); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_edge_pulse;
    int_in[2] = 1'b1;
    tick(1);
    int_in[2] = 1'b0;
    tick(2);
    n_cmp++; if (pending !== 4'b0100) begin n_err++; $display("FAIL pulse_pend_e3: got %b want %b", pending, 4'b0100); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL pulse_irq_e3: got %b want 0", irq); end
    tick(1);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pulse_irq_e4: got %b want 1", irq); end
    n_cmp++; if (irq_id !== 2'd2) begin n_err++; $display("FAIL pulse_id_e4: got %0d want 2", irq_id); end
    n_cmp++; if (irq_valid !== 1'b1) begin n_err++; $display("FAIL pulse_valid_e4: got %b want 1", irq_valid); end
    tick(5);
    n_cmp++; if (pending !== 4'b0100) begin n_err++; $display("FAIL pulse_hold: got %b want %b", pending, 4'b0100); end
    do_ack(2'd2);
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL pulse_ack_pend: got %b want %b", pending, 4'b0000); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pulse_ack_irq_lag: got %b want 1", irq); end
    tick(1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL pulse_ack_irq: got %b want 0", irq); end
  endtask

  task automatic test_debounce;
    debounce_cyc = 4'd3;
    int_in[1] = 1'b1;
    tick(3);
    int_in[1] = 1'b0;
    tick(10);
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL deb_glitch: got %b want %b", pending, 4'b0000); end
    int_in[1] = 1'b1;
    tick(5);
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL deb_early: got %b want %b", pending, 4'b0000); end
    tick(1);
    n_cmp++; if (pending !== 4'b0010) begin n_err++; $display("FAIL deb_set_e6: got %b want %b", pending, 4'b0010); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL deb_irq_e6: got %b want 0", irq); end
    tick(1);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL deb_irq_e7: got %b want 1", irq); end
    n_cmp++; if (irq_id !== 2'd1) begin n_err++; $display("FAIL deb_id_e7: got %0d want 1", irq_id); end
    debounce_cyc = 4'd0;
  endtask

  task automatic test_priority;
    int_in[3] = 1'b1;
    tick(3);
    n_cmp++; if (pending !== 4'b1010) begin n_err++; $display("FAIL prio_pend: got %b want %b", pending, 4'b1010); end
    tick(1);
    n_cmp++; if (irq_id !== 2'd1) begin n_err++; $display("FAIL prio_id_both: got %0d want 1", irq_id); end
    do_ack(2'd1);
    n_cmp++; if (pending !== 4'b1000) begin n_err++; $display("FAIL prio_ack1_pend: got %b want %b", pending, 4'b1000); end
    tick(1);
    n_cmp++; if (irq_id !== 2'd3) begin n_err++; $display("FAIL prio_id_3: got %0d want 3", irq_id); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL prio_irq_3: got %b want 1", irq); end
    do_ack(2'd3);
    tick(1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL prio_irq_none: got %b want 0", irq); end
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL prio_valid_none: got %b want 0", irq_valid); end
    n_cmp++; if (irq_id !== 2'd0) begin n_err++; $display("FAIL prio_id_none: got %0d want 0", irq_id); end
    int_in = 4'b0000;
    tick(4);
  endtask

  task automatic test_nmi_mask;
    int_in[0] = 1'b1;
    tick(3);
    n_cmp++; if (pending !== 4'b0001) begin n_err++; $display("FAIL nmi_pend: got %b want %b", pending, 4'b0001); end
    tick(1);
    n_cmp++; if (nmi !== 1'b1) begin n_err++; $display("FAIL nmi_high: got %b want 1", nmi); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL nmi_irq_low: got %b want 0", irq); end
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL nmi_valid_low: got %b want 0", irq_valid); end
    do_ack(2'd0);
    tick(1);
    n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL nmi_ack: got %b want 0", nmi); end
    int_in[0] = 1'b0;
    tick(4);
    cfg_mask = 4'b1110;
    int_in[0] = 1'b1;
    tick(4);
    n_cmp++; if (pending !== 4'b0001) begin n_err++; $display("FAIL mask_pend: got %b want %b", pending, 4'b0001); end
    n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL mask_nmi_low: got %b want 0", nmi); end
    cfg_mask = 4'hF;
    tick(1);
    n_cmp++; if (nmi !== 1'b1) begin n_err++; $display("FAIL unmask_nmi: got %b want 1", nmi); end
    do_ack(2'd0);
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL mask_ack: got %b want %b", pending, 4'b0000); end
    int_in[0] = 1'b0;
    tick(4);
    int_in[0] = 1'b1;
    tick(2);
    do_ack(2'd0);
    n_cmp++; if (pending !== 4'b0001) begin n_err++; $display("FAIL set_beats_ack: got %b want %b", pending, 4'b0001); end
    tick(1);
    n_cmp++; if (nmi !== 1'b1) begin n_err++; $display("FAIL set_beats_ack_nmi: got %b want 1", nmi); end
    do_ack(2'd0);
    int_in[0] = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_mid;
    int_in = 4'b1110;
    tick(3);
    n_cmp++; if (pending !== 4'b1110) begin n_err++; $display("FAIL mid_pend: got %b want %b", pending, 4'b1110); end
    tick(1);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mid_irq: got %b want 1", irq); end
    rst = 1'b1;
    tick(1);
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL mid_rst_pend: got %b want %b", pending, 4'b0000); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_rst_irq: got %b want 0", irq); end
    n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL mid_rst_nmi: got %b want 0", nmi); end
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", irq_valid); end
    n_cmp++; if (irq_id !== 2'd0) begin n_err++; $display("FAIL mid_rst_id: got %0d want 0", irq_id); end
    tick(1);
    rst = 1'b0;
    tick(2);
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL mid_no_repend: got %b want %b", pending, 4'b0000); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_no_irq: got %b want 0", irq); end
    int_in = 4'b0000;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_level_pol;
    debounce_cyc = 4'd3;
    int_in[3]   = 1'b1;
    cfg_pol[3]  = 1'b1;
    cfg_edge[3] = 1'b0;
    tick(6);
    debounce_cyc = 4'd0;
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL lvl_idle: got %b want %b", pending, 4'b0000); end
    int_in[3] = 1'b0;
    tick(3);
    n_cmp++; if (pending !== 4'b1000) begin n_err++; $display("FAIL lvl_pend: got %b want %b", pending, 4'b1000); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_irq_e3: got %b want 0", irq); end
    tick(1);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_irq_e4: got %b want 1", irq); end
    n_cmp++; if (irq_id !== 2'd3) begin n_err++; $display("FAIL lvl_id: got %0d want 3", irq_id); end
    do_ack(2'd3);
    tick(1);
    n_cmp++; if (pending !== 4'b1000) begin n_err++; $display("FAIL lvl_ack_ignored: got %b want %b", pending, 4'b1000); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_ack_irq: got %b want 1", irq); end
    int_in[3] = 1'b1;
    tick(3);
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL lvl_release_pend: got %b want %b", pending, 4'b0000); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_release_e3: got %b want 1", irq); end
    tick(1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_release_e4: got %b want 0", irq); end
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL lvl_release_valid: got %b want 0", irq_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_edge_pulse();
    test_debounce();
    test_priority();
    test_nmi_mask();
    test_reset_mid();
    test_level_pol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
